// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared types for the RV32I pipeline memory stage. It holds the
//               EX/MEM and MEM/WB bundles, the memory-access FSM states and the
//               load/store funct3 width codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    // funct3 width/extension codes shared by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic        RegWrite;
        logic [1:0]  ResultSrc;
        logic        MemWrite;
        logic [2:0]  funct3;
        logic [31:0] ALUResult;
        logic [31:0] WriteData;
        logic [31:0] PCPlus4;
        logic [4:0]  Rd;
        logic [31:0] ImmExt;
    } exmem_t;

    typedef struct packed {
        logic        RegWrite;
        logic [1:0]  ResultSrc;
        logic [31:0] ALUResult;
        logic [31:0] ReadData;
        logic [31:0] PCPlus4;
        logic [4:0]  Rd;
        logic [31:0] ImmExt;
        logic        Misalign;
    } memwb_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } memstate_t;

endpackage

`default_nettype wire

// File: rtl/mem_align.sv
// ============================================================================
// Module      : mem_align
// Description : Combinational byte-lane logic for the memory stage. It builds
//               store byte enables and lane-replicated store data, extracts and
//               extends load data, and flags misaligned accesses.
// Ports       : funct3    in  width/extension code
//               addr      in  low two address bits
//               WriteData in  store source register value
//               rdata     in  word returned by data memory
//               wstrb     out store byte enables
//               wdata     out lane-replicated store data
//               ReadData  out extracted and extended load value
//               misalign  out access not naturally aligned for its width
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_align
    import pipeline_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] WriteData,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ReadData,
    output logic        misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // funct3[1:0] encodes the access width: 00 byte, 01 half, 10 word
    always_comb begin
        wstrb    = 4'b1111;
        wdata    = WriteData;
        misalign = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << addr;
                wdata = {4{WriteData[7:0]}};
            end
            2'b01: begin
                wstrb    = 4'b0011 << addr;
                wdata    = {2{WriteData[15:0]}};
                misalign = addr[0];
            end
            default: begin
                misalign = (addr != 2'b00);
            end
        endcase
    end

    always_comb begin
        w_byte = rdata[7:0];
        case (addr)
            2'b00:   w_byte = rdata[7:0];
            2'b01:   w_byte = rdata[15:8];
            2'b10:   w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ReadData = rdata;
        case (funct3)
            F3_B:    ReadData = {{24{w_byte[7]}}, w_byte};
            F3_H:    ReadData = {{16{w_half[15]}}, w_half};
            F3_BU:   ReadData = {24'd0, w_byte};
            F3_HU:   ReadData = {16'd0, w_half};
            default: ReadData = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : Memory-access stage of the five-stage RV32I pipeline. Issues
//               loads/stores on a request/grant/response port, stalls the
//               pipeline while an access is outstanding and registers MEM/WB.
// Ports       : clk, rst_n      clock, asynchronous active-low reset
//               inputs          EX/MEM bundle
//               outputs         registered MEM/WB bundle
//               ALUResultM, RdM, RegWriteM  forwarding/hazard copies
//               StallM          holds IF, ID, EX and EX/MEM registers
//               dmem_*          data-memory request/grant/response port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  exmem_t      inputs,
    output memwb_t      outputs,
    output logic [31:0] ALUResultM,
    output logic [4:0]  RdM,
    output logic        RegWriteM,
    output logic        StallM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    memstate_t   r_state;
    memwb_t      r_memwb;
    memwb_t      w_memwb_next;

    logic        w_load;
    logic        w_store;
    logic        w_misalign;
    logic        w_mis_op;
    logic        w_aligned_op;
    logic        w_complete;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_readdata;

    mem_align u_mem_align (
        .funct3    (inputs.funct3),
        .addr      (inputs.ALUResult[1:0]),
        .WriteData (inputs.WriteData),
        .rdata     (dmem_rdata),
        .wstrb     (w_wstrb),
        .wdata     (w_wdata),
        .ReadData  (w_readdata),
        .misalign  (w_misalign)
    );

    assign w_load       = (inputs.ResultSrc == 2'b01);
    assign w_store      = inputs.MemWrite;
    assign w_mis_op     = (w_load | w_store) & w_misalign;
    assign w_aligned_op = (w_load | w_store) & ~w_misalign;

    // A store finishes on its grant; a load only on its response in WAIT.
    assign w_complete = (r_state == WAIT) ? dmem_rvalid : (dmem_gnt & w_store);
    assign StallM     = w_aligned_op & ~w_complete;

    // rst_n gates the request so nothing is issued while the memory is held in reset
    assign dmem_req   = rst_n & (((r_state == IDLE) & w_aligned_op) | (r_state == REQ));
    assign dmem_we    = w_store;
    assign dmem_addr  = {inputs.ALUResult[31:2], 2'b00};
    assign dmem_wstrb = w_store ? w_wstrb : 4'b0000;
    assign dmem_wdata = w_wdata;

    assign ALUResultM = inputs.ALUResult;
    assign RdM        = inputs.Rd;
    assign RegWriteM  = inputs.RegWrite;

    // Misaligned ops retire as a flagged non-writing instruction
    always_comb begin
        w_memwb_next           = '0;
        w_memwb_next.RegWrite  = inputs.RegWrite & ~w_mis_op;
        w_memwb_next.ResultSrc = inputs.ResultSrc;
        w_memwb_next.ALUResult = inputs.ALUResult;
        w_memwb_next.ReadData  = (w_load & ~w_mis_op) ? w_readdata : 32'd0;
        w_memwb_next.PCPlus4   = inputs.PCPlus4;
        w_memwb_next.Rd        = inputs.Rd;
        w_memwb_next.ImmExt    = inputs.ImmExt;
        w_memwb_next.Misalign  = w_mis_op;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_memwb <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_aligned_op) begin
                        if (!dmem_gnt) begin
                            r_state <= REQ;
                        end else if (w_load) begin
                            r_state <= WAIT;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        r_state <= w_load ? WAIT : IDLE;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A stalled cycle retires a bubble so writeback never sees a repeat
            r_memwb <= StallM ? memwb_t'('0) : w_memwb_next;
        end
    end

    assign outputs = r_memwb;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage with a behavioural model of
//               load/store alignment and stall timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    exmem_t      inputs;
    memwb_t      outputs;
    logic [31:0] ALUResultM;
    logic [4:0]  RdM;
    logic        RegWriteM;
    logic        StallM;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int checks = 0;
    int errors = 0;

    int          obs_stalls;
    logic [3:0]  obs_wstrb;
    logic [31:0] obs_wdata;
    logic [31:0] obs_addr;
    memwb_t      obs_out;

    mem_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inputs      (inputs),
        .outputs     (outputs),
        .ALUResultM  (ALUResultM),
        .RdM         (RdM),
        .RegWriteM   (RegWriteM),
        .StallM      (StallM),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wstrb  (dmem_wstrb),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_misaligned(input exmem_t e);
        bit memop;
        memop = (e.ResultSrc == 2'b01) || e.MemWrite;
        return memop && ((int'(e.ALUResult[1:0]) % size_of(e.funct3)) != 0);
    endfunction

    function automatic memwb_t model(input exmem_t e, input logic [31:0] rdata);
        memwb_t      m;
        logic [31:0] v;
        logic [31:0] mask;
        int          nbits;
        bit          mis;
        mis         = is_misaligned(e);
        m           = '0;
        m.RegWrite  = mis ? 1'b0 : e.RegWrite;
        m.ResultSrc = e.ResultSrc;
        m.ALUResult = e.ALUResult;
        m.PCPlus4   = e.PCPlus4;
        m.Rd        = e.Rd;
        m.ImmExt    = e.ImmExt;
        m.Misalign  = mis;
        if (e.ResultSrc == 2'b01 && !mis) begin
            nbits = 8 * size_of(e.funct3);
            v     = rdata >> (8 * int'(e.ALUResult[1:0]));
            if (nbits < 32) begin
                mask = (32'h1 << nbits) - 32'h1;
                v    = v & mask;
                if (!e.funct3[2] && v[nbits-1]) v = v | ~mask;
            end
            m.ReadData = v;
        end
        return m;
    endfunction

    function automatic logic [3:0] model_wstrb(input exmem_t e);
        logic [3:0] s;
        s = 4'((1 << size_of(e.funct3)) - 1);
        return s << e.ALUResult[1:0];
    endfunction

    function automatic logic [31:0] model_wdata(input exmem_t e);
        case (size_of(e.funct3))
            1:       return {4{e.WriteData[7:0]}};
            2:       return {2{e.WriteData[15:0]}};
            default: return e.WriteData;
        endcase
    endfunction

    function automatic exmem_t mk(input bit ld, input bit st, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd);
        exmem_t e;
        e.RegWrite  = ld ? 1'b1 : 1'($urandom);
        e.ResultSrc = ld ? 2'b01 : ($urandom_range(0, 1) ? 2'b10 : 2'b00);
        e.MemWrite  = st;
        e.funct3    = f3;
        e.ALUResult = addr;
        e.WriteData = wd;
        e.PCPlus4   = $urandom;
        e.Rd        = 5'($urandom_range(1, 31));
        e.ImmExt    = $urandom;
        return e;
    endfunction

    // Runs one instruction. Starts and ends just after a rising edge.
    // gd = grant wait cycles, rd = response wait cycles after the grant cycle.
    task automatic do_op(input exmem_t e, input int gd, input int rd, input logic [31:0] rdata);
        bit     ld;
        bit     st;
        bit     aligned;
        int     ncyc;
        int     exp_stalls;
        bit     exp_req;
        memwb_t exp;
        ld         = (e.ResultSrc == 2'b01);
        st         = e.MemWrite;
        aligned    = (ld || st) && !is_misaligned(e);
        exp_stalls = !aligned ? 0 : (st ? gd : 1 + gd + rd);
        ncyc       = exp_stalls + 1;
        exp        = model(e, rdata);
        inputs     = e;
        obs_stalls = 0;
        obs_wstrb  = 4'hx;
        obs_wdata  = 32'hx;
        obs_addr   = 32'hx;
        for (int c = 0; c < ncyc; c++) begin
            dmem_gnt    = aligned && (c == gd);
            dmem_rvalid = aligned && ld && (c == ncyc - 1);
            dmem_rdata  = dmem_rvalid ? rdata : $urandom;
            @(negedge clk);
            if (StallM) obs_stalls++;
            exp_req = aligned && (c <= gd);
            checks++;
            if (dmem_req !== exp_req) begin
                errors++;
                $display("FAIL req cyc%0d: got %b want %b", c, dmem_req, exp_req);
            end
            if (exp_req) begin
                obs_addr  = dmem_addr;
                obs_wstrb = dmem_wstrb;
                obs_wdata = dmem_wdata;
                checks++;
                if (dmem_addr !== {e.ALUResult[31:2], 2'b00} || dmem_we !== st) begin
                    errors++;
                    $display("FAIL addr/we cyc%0d: got %h/%b want %h/%b", c, dmem_addr, dmem_we,
                             {e.ALUResult[31:2], 2'b00}, st);
                end
                if (st) begin
                    checks++;
                    if (dmem_wstrb !== model_wstrb(e) || dmem_wdata !== model_wdata(e)) begin
                        errors++;
                        $display("FAIL wstrb/wdata cyc%0d: got %b/%h want %b/%h", c, dmem_wstrb,
                                 dmem_wdata, model_wstrb(e), model_wdata(e));
                    end
                end
            end
            if (c == 0) begin
                checks++;
                if (ALUResultM !== e.ALUResult || RdM !== e.Rd || RegWriteM !== e.RegWrite) begin
                    errors++;
                    $display("FAIL fwd copies: got %h/%0d/%b want %h/%0d/%b", ALUResultM, RdM,
                             RegWriteM, e.ALUResult, e.Rd, e.RegWrite);
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if (c < ncyc - 1) begin
                if (outputs !== memwb_t'('0)) begin
                    errors++;
                    $display("FAIL bubble cyc%0d: got %h want 0", c, outputs);
                end
            end else if (outputs !== exp) begin
                errors++;
                $display("FAIL memwb: got %h want %h", outputs, exp);
            end
        end
        obs_out = outputs;
        checks++;
        if (obs_stalls != exp_stalls) begin
            errors++;
            $display("FAIL stall count: got %0d want %0d", obs_stalls, exp_stalls);
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        inputs      = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n       = 1'b0;
        inputs      = '0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = '0;
        #1;
        checks++;
        if (outputs !== memwb_t'('0)) begin
            errors++;
            $display("FAIL reset outputs: got %h want 0", outputs);
        end
        inputs = mk(1, 0, F3_W, 32'h40, 32'h0);
        #1;
        checks++;
        if (dmem_req !== 1'b0 || StallM !== 1'b1) begin
            errors++;
            $display("FAIL reset req/stall: got %b/%b want 0/1", dmem_req, StallM);
        end
        inputs = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // retire a non-memory op, then check asynchronous clearing mid-cycle
        do_op(mk(0, 0, F3_W, 32'h1234_5678, 32'h0), 0, 0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outputs !== memwb_t'('0)) begin
            errors++;
            $display("FAIL async reset outputs: got %h want 0", outputs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_sw();
        exmem_t e;
        e          = mk(0, 1, F3_W, 32'h100, 32'hDEAD_BEEF);
        e.RegWrite = 1'b1;
        do_op(e, 0, 0, 32'h0);
        checks++;
        if (obs_wstrb !== 4'b1111 || obs_addr !== 32'h100 || obs_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL SW: got %b/%h/%h want 1111/00000100/deadbeef", obs_wstrb, obs_addr, obs_wdata);
        end
        checks++;
        if (obs_stalls != 0 || obs_out.RegWrite !== 1'b1) begin
            errors++;
            $display("FAIL SW stall/regwrite: got %0d/%b want 0/1", obs_stalls, obs_out.RegWrite);
        end
    endtask

    task automatic test_store_sb();
        do_op(mk(0, 1, F3_B, 32'h103, 32'h0000_00A5), 0, 0, 32'h0);
        checks++;
        if (obs_wstrb !== 4'b1000 || obs_wdata !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL SB: got %b/%h want 1000/a5a5a5a5", obs_wstrb, obs_wdata);
        end
    endtask

    task automatic test_load_lb();
        do_op(mk(1, 0, F3_B, 32'h102, 32'h0), 0, 0, 32'h0080_FF00);
        checks++;
        if (obs_stalls != 1 || obs_out.ReadData !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL LB: got stalls %0d data %h want 1/ffffff80", obs_stalls, obs_out.ReadData);
        end
        do_op(mk(1, 0, F3_BU, 32'h102, 32'h0), 0, 0, 32'h0080_FF00);
        checks++;
        if (obs_out.ReadData !== 32'h0000_0080) begin
            errors++;
            $display("FAIL LBU: got %h want 00000080", obs_out.ReadData);
        end
    endtask

    task automatic test_load_lh_wait();
        do_op(mk(1, 0, F3_H, 32'h102, 32'h0), 2, 1, 32'h8001_1234);
        checks++;
        if (obs_stalls != 4 || obs_out.ReadData !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL LH wait: got stalls %0d data %h want 4/ffff8001", obs_stalls, obs_out.ReadData);
        end
    endtask

    task automatic test_misalign();
        do_op(mk(1, 0, F3_W, 32'h101, 32'h0), 0, 0, 32'h0);
        checks++;
        if (obs_stalls != 0 || obs_out.Misalign !== 1'b1 || obs_out.RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL LW misalign: got stalls %0d mis %b rw %b want 0/1/0", obs_stalls,
                     obs_out.Misalign, obs_out.RegWrite);
        end
    endtask

    task automatic test_reset_mid_access();
        inputs   = mk(1, 0, F3_W, 32'h200, 32'h0);
        dmem_gnt = 1'b1;
        @(posedge clk);
        #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || StallM !== 1'b1) begin
            errors++;
            $display("FAIL wait state req/stall: got %b/%b want 0/1", dmem_req, StallM);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || outputs !== memwb_t'('0)) begin
            errors++;
            $display("FAIL reset in wait: got req %b out %h want 0/0", dmem_req, outputs);
        end
        rst_n = 1'b1;
        #1;
        // back in IDLE with the load still presented, so it is requested again
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL req after reset: got %b want 1", dmem_req);
        end
        inputs = '0;
        @(posedge clk);
        #1;
        do_op(mk(1, 0, F3_HU, 32'h206, 32'h0), 1, 0, 32'hBEEF_0000);
        checks++;
        if (obs_out.ReadData !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL load after reset: got %h want 0000beef", obs_out.ReadData);
        end
    endtask

    task automatic test_random();
        logic [2:0] ld_f3[5];
        logic [2:0] st_f3[3];
        int         kind;
        exmem_t     e;
        ld_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        st_f3 = '{F3_B, F3_H, F3_W};
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0)
                e = mk(0, 0, ld_f3[$urandom_range(0, 4)], $urandom, $urandom);
            else if (kind == 1)
                e = mk(0, 1, st_f3[$urandom_range(0, 2)], $urandom, $urandom);
            else
                e = mk(1, 0, ld_f3[$urandom_range(0, 4)], $urandom, $urandom);
            do_op(e, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end
    endtask

    task automatic test_back_to_back();
        do_op(mk(0, 1, F3_H, 32'h310, 32'h0000_1234), 0, 0, 32'h0);
        do_op(mk(1, 0, F3_W, 32'h310, 32'h0), 0, 0, 32'h1234_5678);
        do_op(mk(1, 0, F3_H, 32'h312, 32'h0), 1, 2, 32'h7FFF_0000);
        checks++;
        if (obs_out.ReadData !== 32'h0000_7FFF) begin
            errors++;
            $display("FAIL back-to-back LH: got %h want 00007fff", obs_out.ReadData);
        end
    endtask

    initial begin
        test_reset();
        test_store_sw();
        test_store_sb();
        test_load_lb();
        test_load_lh_wait();
        test_misalign();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RV32I pipeline. It consumes the EX/MEM bundle produced by the execute stage and performs loads and stores over a request/grant/response data-memory port, stalling the pipeline while an access is outstanding. It aligns store data, extracts and extends load data, and registers the MEM/WB bundle consumed by writeback.

## Interface
Parameters:
- none; the data path is fixed at 32 bits.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `inputs`  in  `exmem_t`  EX/MEM register contents: RegWrite, ResultSrc[1:0], MemWrite, funct3, ALUResult, WriteData, PCPlus4, Rd, ImmExt.
- `outputs`  out  `memwb_t`  registered MEM/WB bundle: RegWrite, ResultSrc, ALUResult, ReadData, PCPlus4, Rd, ImmExt, Misalign.
- `ALUResultM`  out  32  combinational copy of `inputs.ALUResult`, used for EX forwarding.
- `RdM`, `RegWriteM`  out  5/1  combinational copies, used by the hazard unit.
- `StallM`  out  1  holds the IF, ID, EX and EX/MEM registers.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  32  word address, `{ALUResult[31:2],2'b00}`.
- `dmem_wstrb`  out  4  byte enables (stores only).
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_gnt`  in  1  request accepted this cycle.
- `dmem_rvalid`  in  1  load data valid.
- `dmem_rdata`  in  32  load word.

## Operation
- Load = `ResultSrc==2'b01`. Store = `MemWrite`. Memory op = load or store.
- Misaligned access:
  - Halfword access with `addr[0]=1`, or word access with `addr[1:0]!=0`, is misaligned.
  - A misaligned op issues no request and never stalls.
  - It is written to the MEM/WB register with `Misalign=1` and `RegWrite=0`.
- Store alignment:
  - SB: wstrb `0001<<addr[1:0]`, wdata `{4{WriteData[7:0]}}`.
  - SH: wstrb `0011<<addr[1:0]`, wdata `{2{WriteData[15:0]}}`.
  - SW: wstrb `1111`, wdata `WriteData`.
- Load extraction selects the byte or halfword lane by `addr[1:0]`:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- FSM states and transitions:
  - IDLE: `dmem_req=1` for an aligned memory op.
    - gnt=0 → REQ.
    - gnt=1 with a store → op complete, stay in IDLE.
    - gnt=1 with a load → WAIT.
  - REQ: `dmem_req` held asserted with `addr`, `we`, `wstrb` and `wdata` stable until gnt. On gnt, stores complete (→ IDLE) and loads go to WAIT.
  - WAIT: `dmem_req=0`. On rvalid, the load completes and the FSM returns to IDLE. The memory never asserts rvalid in the same cycle as gnt.
- `StallM` = aligned memory op present and not completing this cycle. It is combinational from the state, gnt and rvalid.
- MEM/WB register update:
  - `StallM=0`: captures the bundle. `ReadData` = extracted load data, or 0 for non-loads.
  - `StallM=1`: captures a bubble (all fields 0), so writeback never repeats an instruction.
- Non-memory instructions pass through in one cycle with `ReadData=0`.

## Timing
- Reset (async assert, sync release): FSM = IDLE and every `outputs` field = 0.
  - While `rst_n=0`, `dmem_req` = 0.
  - `StallM`, `ALUResultM`, `RdM` and `RegWriteM` follow `inputs` combinationally; the EX/MEM register upstream is cleared by the same reset.
- Reset mid-access abandons the transaction. The data memory shares `rst_n`, so a stale rvalid cannot arrive afterwards.
- Non-memory op or store with gnt in the issue cycle: zero stall; the MEM/WB register updates at the next edge.
- Load with zero-wait memory (gnt at cycle t, rvalid at t+1): `StallM` high in cycle t and low in t+1. `outputs` holds the load at the edge ending t+1, giving 1 stall cycle.
- Each extra gnt or rvalid wait cycle adds exactly one stall cycle.
- Back-to-back memory ops: the next op is issued in the cycle after completion.

## Structure
- `pipeline_pkg` adds:
  - `memwb_t`;
  - `memstate_t` (IDLE, REQ, WAIT);
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- One combinational sub-module, `mem_align`, takes `funct3`, `addr[1:0]`, `WriteData` and `rdata`. It produces `wstrb`, `wdata`, `ReadData` and `misalign`.
- The FSM and the MEM/WB register live in `mem_stage`.

## Test plan
- SW at 0x100 with data 0xDEADBEEF and gnt in the same cycle → wstrb=1111, addr=0x100, no StallM, memwb.RegWrite=1 as driven by EX.
- SB at 0x103 with data 0x000000A5 → wstrb=1000, wdata=0xA5A5A5A5.
- LB at 0x102 with rdata 0x0080FF00, gnt at t, rvalid at t+1 → StallM high for exactly 1 cycle, ReadData=0xFFFFFF80. LBU on the same access → 0x00000080.
- LH at 0x102 with gnt delayed 2 cycles and rvalid delayed 1 cycle after gnt:
  - 4 stall cycles;
  - req and addr stable while waiting;
  - bubbles in memwb during the stall;
  - ReadData = sign-extended `rdata[31:16]`.
- LW at 0x101 → no req, no stall, memwb.Misalign=1, RegWrite=0.
- Assert `rst_n=0` while in WAIT → immediate IDLE, outputs=0, req=0. After release, a new load completes normally.
